// File: rtl/shift_div_by_const_pkg.sv
// -----------------------------------------------------------------------------
// shift_div_pkg
// Shared types and helpers for the bit-serial constant divider.
//   state_e     : controller states (IDLE, CALC, DONE)
//   rem_width() : remainder width for a given divisor ($clog2)
//   cnt_width() : bit-counter width for a given operand width ($clog2)
// -----------------------------------------------------------------------------
package shift_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operand width of the original fixed divide-by-3 block.
    localparam int DEFAULT_WIDTH = 32'sd14;
    // Counter width for the default operand width.
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Remainder width: the remainder is always < divisor.
    function automatic int rem_width(input int divisor);
        return $clog2(divisor);
    endfunction

    // Counter width: the counter runs from width-1 down to 0.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_div_by_const_step.sv
// -----------------------------------------------------------------------------
// shift_div_step
// One purely combinational restoring-division step by a constant divisor.
// Kept separate so an unrolled or pipelined divider can chain copies of it.
//   rem_in  [REM_W] : partial remainder in (always < DIVISOR)
//   bit_in  [1]     : next dividend bit, MSB first
//   rem_out [REM_W] : partial remainder out (always < DIVISOR)
//   q_bit   [1]     : quotient bit produced by this step
// -----------------------------------------------------------------------------
module shift_div_step
    import shift_div_pkg::*;
#(
    parameter int  DIVISOR = 32'sd3,
    localparam int REM_W   = rem_width(DIVISOR)
) (
    input  logic [REM_W-1:0] rem_in,
    input  logic             bit_in,
    output logic [REM_W-1:0] rem_out,
    output logic             q_bit
);

    // DIVISOR <= 2**REM_W, so it always fits in REM_W+1 bits.
    localparam logic [REM_W:0] DIV_C = (REM_W + 1)'(DIVISOR);

    logic [REM_W:0]   t_s;
    logic [REM_W-1:0] diff_s;

    // Trial subtraction: keep the difference when it does not go negative.
    always_comb begin
        t_s    = {rem_in, bit_in};
        diff_s = REM_W'(t_s - DIV_C);
        if (t_s >= DIV_C) begin
            q_bit   = 1'b1;
            rem_out = diff_s;
        end else begin
            q_bit   = 1'b0;
            rem_out = t_s[REM_W-1:0];
        end
    end

endmodule

// File: rtl/shift_div_by_const.sv
// -----------------------------------------------------------------------------
// shift_div_by_const
// Bit-serial unsigned divide by a compile-time constant, one quotient bit per
// clock, restoring long division MSB first. Valid/ready on both sides with
// back-to-back operation: a new operand may be accepted in the same cycle the
// previous result is taken.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (aborts any operation)
//   in_valid   in   operand valid
//   in_ready   out  operand can be accepted this cycle (from state/out_ready)
//   data_in    in   [WIDTH] unsigned dividend
//   out_valid  out  result valid, held until taken
//   out_ready  in   downstream takes the result
//   quotient   out  [WIDTH] floor(data_in/DIVISOR) (rounded, see below)
//   remainder  out  [REM_W] data_in mod DIVISOR, always the true remainder
//
// Build option
//   SHIFT_DIV_ROUND_EN : when defined, quotient is rounded half-up
//                        (floor + 1 when 2*remainder >= DIVISOR); the
//                        increment happens in the result-load cycle, so
//                        latency is unchanged.
// -----------------------------------------------------------------------------
module shift_div_by_const
    import shift_div_pkg::*;
#(
    parameter int  WIDTH   = DEFAULT_WIDTH,
    parameter int  DIVISOR = 32'sd3,
    localparam int REM_W   = rem_width(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [REM_W-1:0] remainder
);

    localparam int CNT_W = cnt_width(WIDTH);

    // Reject illegal configurations at elaboration time.
    if (WIDTH < 32'sd2) begin : g_bad_width
        $error("shift_div_by_const: WIDTH must be at least 2");
    end
    if (DIVISOR < 32'sd2 || $clog2(DIVISOR + 32'sd1) > WIDTH) begin : g_bad_divisor
        $error("shift_div_by_const: DIVISOR must satisfy 2 <= DIVISOR < 2**WIDTH");
    end

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] dividend_q,  dividend_d;
    logic [REM_W-1:0] rem_q,       rem_d;
    logic [WIDTH-2:0] quot_acc_q,  quot_acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [REM_W-1:0] remainder_q, remainder_d;

    logic             in_ready_s;
    logic [REM_W-1:0] step_rem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] q_floor_s;

    shift_div_step #(
        .DIVISOR (DIVISOR)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dividend_q[WIDTH-1]),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Full floor quotient once the current step's bit is appended.
    assign q_floor_s = {quot_acc_q, step_q_s};

`ifdef SHIFT_DIV_ROUND_EN
    localparam logic [REM_W:0] DIV_C = (REM_W + 1)'(DIVISOR);
    logic             round_up_s;
    logic [WIDTH-1:0] q_final_s;

    // Round half-up; cannot overflow because DIVISOR >= 2.
    always_comb begin
        round_up_s = ({step_rem_s, 1'b0} >= DIV_C);
        q_final_s  = q_floor_s + WIDTH'(round_up_s);
    end
`else
    logic [WIDTH-1:0] q_final_s;
    assign q_final_s = q_floor_s;
`endif

    // Controller: next state, datapath updates and in_ready.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        rem_d       = rem_q;
        quot_acc_d  = quot_acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        in_ready_s  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    dividend_d = data_in;
                    rem_d      = {REM_W{1'b0}};
                    quot_acc_d = {(WIDTH-1){1'b0}};
                    cnt_d      = CNT_W'(WIDTH - 32'sd1);
                    state_d    = CALC;
                end else begin
                    state_d = IDLE;
                end
            end

            CALC: begin
                rem_d      = step_rem_s;
                dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
                quot_acc_d = q_floor_s[WIDTH-2:0];
                if (cnt_q == CNT_W'(0)) begin
                    // Last bit: load the result registers directly.
                    quotient_d  = q_final_s;
                    remainder_d = step_rem_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = CALC;
                end
            end

            DONE: begin
                // Accept the next operand in the same cycle the result leaves.
                in_ready_s = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        dividend_d = data_in;
                        rem_d      = {REM_W{1'b0}};
                        quot_acc_d = {(WIDTH-1){1'b0}};
                        cnt_d      = CNT_W'(WIDTH - 32'sd1);
                        state_d    = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dividend_q  <= {WIDTH{1'b0}};
            rem_q       <= {REM_W{1'b0}};
            quot_acc_q  <= {(WIDTH-1){1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {REM_W{1'b0}};
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            rem_q       <= rem_d;
            quot_acc_q  <= quot_acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
